bdd_walk_ctrl: RTL
==================

BDD_WALK_CTRL -- requirements
Module: bdd_walk_ctrl

Interface
REQ-001 SHALL have parameter ROOT_ADDR, default 0, giving the node address where every traversal starts.
REQ-002 SHALL have parameter MAX_DEPTH, default 16, range 1..63, giving the maximum number of nodes evaluated per traversal.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_feat (input, 32): the feature vector, with f1=[31:24], f2=[23:16], f3=[15:8], f4=[7:0], each unsigned.
REQ-006 SHALL have ports mem_rd_en (output, 1), mem_addr (output, 6) and mem_rdata (input, 54): the node SRAM read port, whose data is valid exactly one cycle after mem_rd_en.
REQ-007 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_class (output, 6) and out_err (output, 1): the classification result.
REQ-008 SHALL decode the node word as c1=[53:48], c2=[47:42], c3=[41:36], c4=[35:30] (unsigned coefficients), thr=[29:14] (16 bits), left=[13:7] and right=[6:0].
REQ-009 SHALL decode each 7-bit child field as bit6=leaf flag and [5:0]=class id when leaf=1, or next node address when leaf=0.

Function
REQ-010 SHALL implement the FSM states IDLE, FETCH, WAIT, EVAL and DONE.
REQ-011 SHALL drive in_ready=1 only in IDLE; on in_valid&in_ready it SHALL latch in_feat, set addr=ROOT_ADDR, clear depth and go to FETCH.
REQ-012 In FETCH it SHALL drive mem_rd_en=1 with mem_addr=addr for exactly one cycle, then go to WAIT; mem_rd_en SHALL be 0 in all other states.
REQ-013 In WAIT it SHALL register mem_rdata into the node register, increment depth and go to EVAL.
REQ-014 In EVAL it SHALL compute sum=f1*c1+f2*c2+f3*c3+f4*c4 as unsigned 16-bit arithmetic; the maximum is 4*255*63=64260, so no overflow or saturation is needed.
REQ-015 In EVAL it SHALL select the left child if sum<thr and the right child otherwise; sum==thr SHALL select right.
REQ-016 In EVAL, if the selected child is a leaf, it SHALL set out_class=child[5:0], out_err=0 and go to DONE.
REQ-017 In EVAL, if the child is not a leaf and depth==MAX_DEPTH, it SHALL set out_class=0, out_err=1 and go to DONE.
REQ-018 In EVAL, if the child is not a leaf and depth<MAX_DEPTH, it SHALL set addr=child[5:0] and go to FETCH.
REQ-019 In DONE it SHALL hold out_valid=1 with out_class and out_err stable until out_ready=1; on that cycle it SHALL go to IDLE, and out_valid SHALL be 0 on the next cycle.
REQ-020 SHALL assert out_valid exactly 1+3N cycles after the input handshake, where N is the number of nodes evaluated, when out_ready is held high.
REQ-021 SHALL ignore in_valid outside IDLE, and SHALL not pipeline or overlap traversals.
REQ-022 SHALL tolerate mem_rdata being X outside the WAIT cycle.

Reset
REQ-023 When rst_n=0 at a clock edge, it SHALL set state=IDLE, mem_rd_en=0, mem_addr=0, out_valid=0, out_class=0, out_err=0 and depth=0.
REQ-024 SHALL give in_ready=1 on the first cycle after rst_n returns high.
REQ-025 Reset asserted in any state, including mid-traversal, SHALL abandon the traversal with no result output.

Structure
REQ-026 SHALL place NODE_W=54, ADDR_W=6, FEAT_W=8, COEF_W=6, THR_W=16, the node field offsets and the FSM state enum in a shared package bdd_pkg.
REQ-027 SHALL put the dot product and compare in one combinational sub-module bdd_node_eval (inputs: features and node word; outputs: sum and the selected child); all sequencing SHALL stay in bdd_walk_ctrl.

Verification
REQ-028 Left leaf: feat=(10,20,30,40), node0 c=(1,2,3,4), thr=301, left=0x45 -> sum=300, out_class=5, out_err=0, out_valid 4 cycles after the handshake.
REQ-029 Tie goes right: same input with node0 thr=300 and right=0x01, node1 c=0, thr=0, right=0x49 -> out_class=9, out_valid 7 cycles after the handshake, and mem_addr sequence 0,1.
REQ-030 Loop/depth limit: MAX_DEPTH=4 and node0 right=0x00 (self) with thr=0 -> out_err=1, out_class=0, 4 reads issued, out_valid 13 cycles after the handshake.
REQ-031 Max arithmetic: all features 255, all coefficients 63, thr=0xFFFF -> sum=64260, left child taken; thr=64260 -> right child taken.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_class and out_err stable, in_ready=0; after out_ready=1, in_ready=1 on the following cycle.
REQ-033 Reset mid-op: rst_n=0 for 1 cycle during WAIT -> next cycle mem_rd_en=0 and out_valid=0, then in_ready=1; no stale result appears afterwards.

Source files
------------

// File: rtl/bdd_pkg.sv
// -----------------------------------------------------------------------------
// bdd_pkg
// Shared definitions for the binary-decision-tree walker: data widths, node
// word field offsets, walker FSM state encoding and small field-extraction
// helpers used by both the controller and the node evaluator.
//
// Node word layout (54 bits, MSB first):
//   c1[53:48] c2[47:42] c3[41:36] c4[35:30] thr[29:14] left[13:7] right[6:0]
// Child field (7 bits): bit6 = leaf flag, [5:0] = class id (leaf) or next
// node address (non-leaf).
// -----------------------------------------------------------------------------
package bdd_pkg;

    localparam int NODE_W   = 54;
    localparam int ADDR_W   = 6;
    localparam int FEAT_W   = 8;
    localparam int COEF_W   = 6;
    localparam int THR_W    = 16;
    localparam int CHILD_W  = 7;
    localparam int SUM_W    = 16;
    localparam int NFEAT    = 4;
    localparam int FVEC_W   = NFEAT * FEAT_W;
    localparam int DEPTH_W  = 6;
    localparam int CLASS_W  = 6;

    // Node word field offsets (LSB positions)
    localparam int C1_LSB    = 48;
    localparam int C2_LSB    = 42;
    localparam int C3_LSB    = 36;
    localparam int C4_LSB    = 30;
    localparam int THR_LSB   = 14;
    localparam int LEFT_LSB  = 7;
    localparam int RIGHT_LSB = 0;
    localparam int LEAF_BIT  = 6;

    // Walker FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EVAL  = 3'd3,
        ST_DONE  = 3'd4
    } bdd_state_e;

    // Coefficient idx (0..3 -> c1..c4) of a node word
    function automatic logic [COEF_W-1:0] node_coef(input logic [NODE_W-1:0] node,
                                                    input int unsigned       idx);
        logic [COEF_W-1:0] c;
        case (idx)
            32'd0:   c = node[C1_LSB +: COEF_W];
            32'd1:   c = node[C2_LSB +: COEF_W];
            32'd2:   c = node[C3_LSB +: COEF_W];
            32'd3:   c = node[C4_LSB +: COEF_W];
            default: c = {COEF_W{1'b0}};
        endcase
        return c;
    endfunction

    // Feature idx (0..3 -> f1..f4) of the packed feature vector; f1 is the MSB byte
    function automatic logic [FEAT_W-1:0] feat_sel(input logic [FVEC_W-1:0] feat,
                                                   input int unsigned       idx);
        logic [FEAT_W-1:0] f;
        case (idx)
            32'd0:   f = feat[31:24];
            32'd1:   f = feat[23:16];
            32'd2:   f = feat[15:8];
            32'd3:   f = feat[7:0];
            default: f = {FEAT_W{1'b0}};
        endcase
        return f;
    endfunction

    // Leaf flag of a child field
    function automatic logic child_is_leaf(input logic [CHILD_W-1:0] child);
        return child[LEAF_BIT];
    endfunction

    // Class id / next address payload of a child field
    function automatic logic [ADDR_W-1:0] child_payload(input logic [CHILD_W-1:0] child);
        return child[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/bdd_node_eval.sv
// -----------------------------------------------------------------------------
// bdd_node_eval
// Purely combinational node evaluator: dot product of the four 8-bit features
// with the four 6-bit node coefficients, compared against the node threshold
// to pick a child. A tie (sum == thr) selects the right child.
//
// Ports:
//   feat  [31:0]  feature vector f1..f4 (f1 in the top byte)
//   node  [53:0]  node word
//   sum   [15:0]  f1*c1 + f2*c2 + f3*c3 + f4*c4 (max 64260, never wraps)
//   child [6:0]   selected child field (left if sum < thr, else right)
// -----------------------------------------------------------------------------
module bdd_node_eval
    import bdd_pkg::*;
(
    input  logic [FVEC_W-1:0]  feat,
    input  logic [NODE_W-1:0]  node,
    output logic [SUM_W-1:0]   sum,
    output logic [CHILD_W-1:0] child
);

    logic [SUM_W-1:0] thr_s;

    // Dot product and threshold compare
    always_comb begin
        sum   = {SUM_W{1'b0}};
        child = {CHILD_W{1'b0}};
        thr_s = node[THR_LSB +: THR_W];
        for (int i = 0; i < NFEAT; i++) begin
            sum = sum + (SUM_W'(feat_sel(feat, i)) * SUM_W'(node_coef(node, i)));
        end
        if (sum < thr_s) begin
            child = node[LEFT_LSB +: CHILD_W];
        end else begin
            child = node[RIGHT_LSB +: CHILD_W];
        end
    end

endmodule

// File: rtl/bdd_walk_ctrl.sv
// -----------------------------------------------------------------------------
// bdd_walk_ctrl
// Walks a binary decision tree stored in a node SRAM. One traversal at a time:
// accept a feature vector, fetch nodes starting at ROOT_ADDR, evaluate each
// node and follow the chosen child until a leaf gives the class or MAX_DEPTH
// nodes have been evaluated without reaching one (reported via out_err).
// Each node costs three cycles (FETCH, WAIT, EVAL).
//
// Parameters:
//   ROOT_ADDR  node address where every traversal starts
//   MAX_DEPTH  maximum nodes evaluated per traversal (1..63)
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     feature handshake, in_feat[31:0] = f1..f4
//   mem_rd_en/mem_addr    node SRAM read request (data next cycle)
//   mem_rdata[53:0]       node SRAM read data
//   out_valid/out_ready   result handshake
//   out_class[5:0]        class id of the reached leaf (0 on error)
//   out_err               depth limit hit without reaching a leaf
// -----------------------------------------------------------------------------
module bdd_walk_ctrl
    import bdd_pkg::*;
#(
    parameter int unsigned ROOT_ADDR = 0,
    parameter int unsigned MAX_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [FVEC_W-1:0]   in_feat,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [NODE_W-1:0]   mem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CLASS_W-1:0]  out_class,
    output logic                out_err
);

    localparam logic [ADDR_W-1:0]  ROOT_C  = ADDR_W'(ROOT_ADDR);
    localparam logic [DEPTH_W-1:0] DEPTH_C = DEPTH_W'(MAX_DEPTH);

    bdd_state_e           state_r;
    logic [FVEC_W-1:0]    feat_r;
    logic [ADDR_W-1:0]    addr_r;
    logic [DEPTH_W-1:0]   depth_r;
    logic [NODE_W-1:0]    node_r;
    logic                 mem_rd_en_r;
    logic                 out_valid_r;
    logic [CLASS_W-1:0]   out_class_r;
    logic                 out_err_r;

    // The evaluator exports the raw sum for observability; sequencing only
    // needs the selected child.
    logic [SUM_W-1:0]     eval_sum_unused_s;
    logic [CHILD_W-1:0]   child_s;

    bdd_node_eval u_eval (
        .feat  (feat_r),
        .node  (node_r),
        .sum   (eval_sum_unused_s),
        .child (child_s)
    );

    assign in_ready  = (state_r == ST_IDLE);
    assign mem_rd_en = mem_rd_en_r;
    assign mem_addr  = addr_r;
    assign out_valid = out_valid_r;
    assign out_class = out_class_r;
    assign out_err   = out_err_r;

    // Walker FSM: all state, request and result registers.
    // mem_rd_en_r is raised on every transition into FETCH and dropped on the
    // way out, so it is high for exactly the FETCH cycle. mem_rdata is only
    // sampled at the end of WAIT, so X on the bus elsewhere is harmless.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            feat_r      <= {FVEC_W{1'b0}};
            addr_r      <= {ADDR_W{1'b0}};
            depth_r     <= {DEPTH_W{1'b0}};
            node_r      <= {NODE_W{1'b0}};
            mem_rd_en_r <= 1'b0;
            out_valid_r <= 1'b0;
            out_class_r <= {CLASS_W{1'b0}};
            out_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        feat_r      <= in_feat;
                        addr_r      <= ROOT_C;
                        depth_r     <= {DEPTH_W{1'b0}};
                        mem_rd_en_r <= 1'b1;
                        state_r     <= ST_FETCH;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    mem_rd_en_r <= 1'b0;
                    state_r     <= ST_WAIT;
                end
                ST_WAIT: begin
                    node_r  <= mem_rdata;
                    depth_r <= depth_r + 6'd1;
                    state_r <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (child_is_leaf(child_s)) begin
                        out_class_r <= child_payload(child_s);
                        out_err_r   <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else if (depth_r >= DEPTH_C) begin
                        // Depth budget spent on a non-leaf: likely a cycle in the tree
                        out_class_r <= {CLASS_W{1'b0}};
                        out_err_r   <= 1'b1;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        addr_r      <= child_payload(child_s);
                        mem_rd_en_r <= 1'b1;
                        state_r     <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a quiet idle
                    mem_rd_en_r <= 1'b0;
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
